// File: rtl/game_state_controller_pkg.sv
// Shared constants for the Frogger game-flow controller.
// Holds the state encodings, the default timing and lives parameters, and a
// helper that sizes the counters.
package game_state_controller_pkg;

    // Encodings are also driven out on o_State for the debug LEDs.
    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StRunning  = 3'd1,
        StDying    = 3'd2,
        StGameOver = 3'd3,
        StWin      = 3'd4
    } game_state_e;

    localparam int unsigned LivesIniDefault    = 3;
    localparam int unsigned DeathCyclesDefault = 25_000_000;  // 1 s at 25 MHz
    localparam int unsigned BlinkCyclesDefault = 3_125_000;
    localparam int unsigned MaxScoreDefault    = 9;

    // Width of a counter running 0..limit-1. The result is at least 1 bit so that a
    // limit of 1 still gives a legal vector.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/game_state_controller_edge_detect.sv
// Rising-edge detector.
// The previous-value register has a configurable reset value. With ResetVal = 1,
// an input that is already high when reset is released produces no pulse.
// Ports:
//   i_Clk, i_Reset : clock, synchronous active-high reset
//   i_Sig          : level input
//   o_Rise         : high in the cycle i_Sig is high after having been low
module game_state_controller_edge_detect #(
    parameter bit ResetVal = 1'b0
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Sig,
    output logic o_Rise
);

    logic prev_q;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            prev_q <= ResetVal;
        end else begin
            prev_q <= i_Sig;
        end
    end

    assign o_Rise = i_Sig & ~prev_q;

endmodule

// File: rtl/game_state_controller.sv
// Game-flow controller for Frogger: IDLE -> RUNNING -> DYING -> (RUNNING | GAME_OVER),
// and RUNNING -> WIN. It tracks lives, times the death/blink phase, and holds the
// game-over and win screens until the next start edge.
// Ports:
//   i_Clk, i_Reset   : 25 MHz clock, synchronous active-high reset
//   i_All_Switch     : AND of the debounced switches; its rising edge is "start"
//   i_Has_Collided   : collision level from Collisions
//   i_Level_Up       : one-cycle pulse when the frog reaches the top
//   i_Score          : current score
//   o_Game_Active    : high in RUNNING only
//   o_Frog_Respawn   : one-cycle pulse in the first cycle of RUNNING
//   o_Frog_Visible   : frog sprite enable (blinks while DYING)
//   o_Lives          : remaining lives
//   o_Game_Over      : high in GAME_OVER
//   o_State          : state encoding
module game_state_controller
    import game_state_controller_pkg::*;
#(
    parameter int unsigned C_LIVES_INI    = LivesIniDefault,
    parameter int unsigned C_DEATH_CYCLES = DeathCyclesDefault,
    parameter int unsigned C_BLINK_CYCLES = BlinkCyclesDefault,
    parameter int unsigned C_MAX_SCORE    = MaxScoreDefault
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_All_Switch,
    input  logic       i_Has_Collided,
    input  logic       i_Level_Up,
    input  logic [3:0] i_Score,
    output logic       o_Game_Active,
    output logic       o_Frog_Respawn,
    output logic       o_Frog_Visible,
    output logic [1:0] o_Lives,
    output logic       o_Game_Over,
    output logic [2:0] o_State
);

    localparam int unsigned DeathW = cnt_width(C_DEATH_CYCLES);
    localparam int unsigned BlinkW = cnt_width(C_BLINK_CYCLES);

    localparam logic [DeathW-1:0] DeathLast = DeathW'(C_DEATH_CYCLES - 1);
    localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(C_BLINK_CYCLES - 1);
    localparam logic [1:0]        LivesIni  = 2'(C_LIVES_INI);
    localparam logic [3:0]        MaxScore  = 4'(C_MAX_SCORE);

    game_state_e       state_q, state_d;
    logic [1:0]        lives_q, lives_d;
    logic [DeathW-1:0] death_cnt_q, death_cnt_d;
    logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
    logic              respawn_q, respawn_d;
    logic              visible_q, visible_d;
    logic              start;

    // Previous-value reset of 1: switches held through reset never count as a start.
    game_state_controller_edge_detect #(
        .ResetVal (1'b1)
    ) u_start_edge (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_Sig   (i_All_Switch),
        .o_Rise  (start)
    );

    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        death_cnt_d = death_cnt_q;
        blink_cnt_d = blink_cnt_q;
        respawn_d   = 1'b0;
        visible_d   = visible_q;

        unique case (state_q)
            StIdle: begin
                lives_d   = LivesIni;
                visible_d = 1'b1;
                if (start) begin
                    state_d   = StRunning;
                    respawn_d = 1'b1;
                end
            end

            StRunning: begin
                // Collision has priority over a winning level-up in the same cycle.
                if (i_Has_Collided) begin
                    state_d     = StDying;
                    lives_d     = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
                    death_cnt_d = '0;
                    blink_cnt_d = '0;
                    visible_d   = 1'b0;
                end else if (i_Level_Up && (i_Score >= MaxScore)) begin
                    state_d   = StWin;
                    visible_d = 1'b1;
                end
            end

            StDying: begin
                if (death_cnt_q == DeathLast) begin
                    death_cnt_d = '0;
                    blink_cnt_d = '0;
                    visible_d   = 1'b1;
                    if (lives_q == 2'd0) begin
                        state_d = StGameOver;
                    end else begin
                        state_d   = StRunning;
                        respawn_d = 1'b1;
                    end
                end else begin
                    death_cnt_d = death_cnt_q + DeathW'(1);
                    if (blink_cnt_q == BlinkLast) begin
                        blink_cnt_d = '0;
                        visible_d   = ~visible_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + BlinkW'(1);
                    end
                end
            end

            StGameOver, StWin: begin
                visible_d = 1'b1;
                if (start) begin
                    state_d = StIdle;
                    // Reload on the transition so the first IDLE cycle already shows full lives.
                    lives_d = LivesIni;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q     <= StIdle;
            lives_q     <= LivesIni;
            death_cnt_q <= '0;
            blink_cnt_q <= '0;
            respawn_q   <= 1'b0;
            visible_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            death_cnt_q <= death_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            respawn_q   <= respawn_d;
            visible_q   <= visible_d;
        end
    end

    assign o_Game_Active  = (state_q == StRunning);
    assign o_Game_Over    = (state_q == StGameOver);
    assign o_Frog_Respawn = respawn_q;
    assign o_Frog_Visible = visible_q;
    assign o_Lives        = lives_q;
    assign o_State        = state_q;

endmodule
